// File: rtl/lpddr3_odt_phase_gen.sv
// LPDDR3 ODT phase generator.
// Turns write-command events, tagged with a phase slot, into the 4-phase
// TX_DATA/OE_DATA lanes of the ODT pin's IOD output stage. It also sequences
// the IOD delay-line load/move/direction controls.
module lpddr3_odt_phase_gen #(
    parameter int LAT_MAX = 31,
    parameter int LEN_MAX = 31
) (
    input  logic       FAB_CLK,
    input  logic       TX_SYNC_RST,
    input  logic       WR_CMD_VALID,
    input  logic [1:0] WR_CMD_PHASE,
    input  logic [5:0] ODT_LAT,
    input  logic [5:0] ODT_LEN,
    input  logic       ODT_FORCE,
    output logic [3:0] TX_DATA,
    output logic [3:0] OE_DATA,
    output logic       ODT_ACTIVE,
    input  logic       DLY_LOAD_REQ,
    input  logic       DLY_REQ,
    input  logic       DLY_DIR,
    input  logic [7:0] DLY_TAPS,
    output logic       DLY_BUSY,
    output logic       DLY_DONE,
    output logic       DLY_ERR,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_LOAD,
    input  logic       DELAY_LINE_OUT_OF_RANGE
);

    // Window depth in FAB_CLK cycles. It covers the furthest phase a command
    // can reach: phase 3 + LAT_MAX + LEN_MAX.
    localparam int DEPTH = (LAT_MAX + LEN_MAX + 3 + 3) / 4 + 1;
    localparam int WIN_W = 4 * DEPTH;
    localparam logic [5:0] LAT_MAX_V = 6'(LAT_MAX);
    localparam logic [5:0] LEN_MAX_V = 6'(LEN_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_MOVE,
        S_GAP,
        S_DONE
    } dly_state_e;

    logic [5:0]       lat_eff;
    logic [5:0]       len_eff;
    logic [6:0]       win_lo;
    logic [6:0]       win_hi;
    logic [WIN_W-1:0] cmd_mask;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] win_merged;
    logic [3:0]       tx_next;
    dly_state_e       state;
    logic [7:0]       tap_cnt;

    // Clamp latency to the supported range; a zero length acts as one phase.
    always_comb begin
        lat_eff = (ODT_LAT > LAT_MAX_V) ? LAT_MAX_V : ODT_LAT;
        len_eff = ODT_LEN;
        if (ODT_LEN == 6'd0) begin
            len_eff = 6'd1;
        end else if (ODT_LEN > LEN_MAX_V) begin
            len_eff = LEN_MAX_V;
        end
    end

    // Timeline window [win_lo, win_hi) in phases, counted from phase 0 of the next cycle.
    assign win_lo = 7'(WR_CMD_PHASE) + 7'(lat_eff);
    assign win_hi = win_lo + 7'(len_eff);

    // Build this cycle's command mask over the whole window register.
    always_comb begin
        // NOTE: default first, so that no path through the block leaves
        // cmd_mask unassigned and infers a latch.
        cmd_mask = '0;
        if (WR_CMD_VALID) begin
            for (int i = 0; i < WIN_W; i++) begin
                if ((7'(i) >= win_lo) && (7'(i) < win_hi)) begin
                    cmd_mask[i] = 1'b1;
                end
            end
        end
    end

    // OR-ing the new mask into the pending window merges overlapping or abutting windows.
    assign win_merged = win_q | cmd_mask;
    assign tx_next    = ODT_FORCE ? 4'hF : win_merged[3:0];

    // Shift the window one cycle (4 phases) and register the lane outputs.
    always_ff @(posedge FAB_CLK) begin
        // NOTE: non-blocking assignments throughout, so every register
        // samples its pre-edge value and there are no ordering races.
        if (TX_SYNC_RST) begin
            win_q      <= '0;
            TX_DATA    <= 4'h0;
            OE_DATA    <= 4'h0;
            ODT_ACTIVE <= 1'b0;
        end else begin
            win_q      <= {4'h0, win_merged[WIN_W-1:4]};
            TX_DATA    <= tx_next;
            OE_DATA    <= 4'hF;
            ODT_ACTIVE <= |tx_next;
        end
    end

    // Delay-line sequencer. Each output is set on entry to the state that owns it.
    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            state                <= S_IDLE;
            tap_cnt              <= 8'd0;
            DLY_BUSY             <= 1'b0;
            DLY_DONE             <= 1'b0;
            DLY_ERR              <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            DELAY_LINE_DIRECTION <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
        end else begin
            DELAY_LINE_MOVE <= 1'b0;
            DELAY_LINE_LOAD <= 1'b0;
            DLY_DONE        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (DLY_LOAD_REQ) begin
                        state           <= S_LOAD;
                        DELAY_LINE_LOAD <= 1'b1;
                        DLY_BUSY        <= 1'b1;
                        DLY_ERR         <= 1'b0;
                    end else if (DLY_REQ) begin
                        state                <= S_SETUP;
                        tap_cnt              <= DLY_TAPS;
                        DELAY_LINE_DIRECTION <= DLY_DIR;
                        DLY_BUSY             <= 1'b1;
                        DLY_ERR              <= 1'b0;
                    end
                end
                S_LOAD: begin
                    state    <= S_DONE;
                    DLY_DONE <= 1'b1;
                end
                S_SETUP: begin
                    if (tap_cnt == 8'd0) begin
                        state    <= S_DONE;
                        DLY_DONE <= 1'b1;
                    end else begin
                        state           <= S_MOVE;
                        DELAY_LINE_MOVE <= 1'b1;
                    end
                end
                S_MOVE: begin
                    tap_cnt <= tap_cnt - 8'd1;
                    if (DELAY_LINE_OUT_OF_RANGE) begin
                        state    <= S_DONE;
                        DLY_DONE <= 1'b1;
                        DLY_ERR  <= 1'b1;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (DELAY_LINE_OUT_OF_RANGE) begin
                        state    <= S_DONE;
                        DLY_DONE <= 1'b1;
                        DLY_ERR  <= 1'b1;
                    end else if (tap_cnt == 8'd0) begin
                        state    <= S_DONE;
                        DLY_DONE <= 1'b1;
                    end else begin
                        state           <= S_MOVE;
                        DELAY_LINE_MOVE <= 1'b1;
                    end
                end
                S_DONE: begin
                    state                <= S_IDLE;
                    DLY_BUSY             <= 1'b0;
                    DELAY_LINE_DIRECTION <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    DLY_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule
